// File: rtl/prim_ram_scrub_pkg.sv
// Shared definitions for the port-B scrub controller.
//   scrub_state_e : controller FSM states
//   RerrCorrBit   : b_rerror_i bit flagging a corrected (single-bit) error
//   RerrUncorrBit : b_rerror_i bit flagging an uncorrectable error
package prim_ram_scrub_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT_WR,
    SCRUB_WAIT,
    SCRUB_RD,
    SCRUB_RSP,
    SCRUB_WB
  } scrub_state_e;

  localparam int unsigned RerrCorrBit   = 0;
  localparam int unsigned RerrUncorrBit = 1;

endpackage

// File: rtl/prim_ram_sat_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk_i, rst_ni : clock, async active-low reset
//   inc           : count up by one (holds at all-ones)
//   clr           : zero the counter, takes priority over inc
//   cnt           : current count
module prim_ram_sat_cnt #(
  parameter int CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc,
  input  logic            clr,
  output logic [CntW-1:0] cnt
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CntW{1'b1}})) begin
      cnt <= cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/prim_ram_2p_scrub_ctrl.sv
// Background controller for port B of a 2-port ECC RAM: zero-fills the
// array on request, then walks it with periodic reads, writing corrected
// data back and logging uncorrectable errors.
//   clk_i, rst_ni          : clock, async active-low reset
//   init_req_i             : pulse, request a full zero-fill
//   scrub_en_i             : enable background scrubbing
//   scrub_period_i         : idle cycles between scrub reads (0 -> 1 cycle)
//   clr_cnt_i              : clear both error counters
//   b_req_o/b_write_o      : port-B request / write strobe
//   b_addr_o/b_wdata_o     : port-B address / write data
//   b_rvalid_i/b_rdata_i   : port-B read response and corrected data
//   b_rerror_i             : [0] correctable, [1] uncorrectable
//   busy_o                 : init or scrub item in flight
//   init_done_o            : sticky zero-fill complete
//   scrub_pass_o           : pulse when the scrub address wraps
//   uncorr_o/uncorr_addr_o : pulse and address of last uncorrectable error
//   corr_cnt_o/uncorr_cnt_o: saturating error counters
module prim_ram_2p_scrub_ctrl
  import prim_ram_scrub_pkg::*;
#(
  parameter int Depth   = 512,
  parameter int Width   = 32,
  parameter int CntW    = 16,
  parameter int PeriodW = 16,
  localparam int SramAw = $clog2(Depth)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               init_req_i,
  input  logic               scrub_en_i,
  input  logic [PeriodW-1:0] scrub_period_i,
  input  logic               clr_cnt_i,
  output logic               b_req_o,
  output logic               b_write_o,
  output logic [SramAw-1:0]  b_addr_o,
  output logic [Width-1:0]   b_wdata_o,
  input  logic               b_rvalid_i,
  input  logic [Width-1:0]   b_rdata_i,
  input  logic [1:0]         b_rerror_i,
  output logic               busy_o,
  output logic               init_done_o,
  output logic               scrub_pass_o,
  output logic               uncorr_o,
  output logic [SramAw-1:0]  uncorr_addr_o,
  output logic [CntW-1:0]    corr_cnt_o,
  output logic [CntW-1:0]    uncorr_cnt_o
);

  localparam logic [SramAw-1:0] AddrMax = SramAw'(Depth - 1);

  scrub_state_e       state_q, state_d;
  logic               init_pend_q, init_done_q;
  logic [SramAw-1:0]  init_addr_q, scrub_addr_q, uncorr_addr_q;
  logic [PeriodW-1:0] wait_cnt_q;
  logic [Width-1:0]   wb_data_q;
  logic               uncorr_q, scrub_pass_q;

  logic start_init, load_wait;
  logic rsp_fire, rsp_corr, rsp_uncorr, item_done, init_last;

  // Responses are only meaningful while a read is outstanding.
  assign rsp_fire   = (state_q == SCRUB_RSP) && b_rvalid_i;
  assign rsp_uncorr = rsp_fire && b_rerror_i[RerrUncorrBit];
  assign rsp_corr   = rsp_fire && b_rerror_i[RerrCorrBit] && !b_rerror_i[RerrUncorrBit];
  // An item ends on a clean/uncorrectable response or after the write-back.
  assign item_done  = (rsp_fire && !rsp_corr) || (state_q == SCRUB_WB);
  assign init_last  = (init_addr_q == AddrMax);

  always_comb begin
    state_d    = state_q;
    start_init = 1'b0;
    load_wait  = 1'b0;
    b_req_o    = 1'b0;
    b_write_o  = 1'b0;
    b_addr_o   = scrub_addr_q;
    b_wdata_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (init_pend_q) begin
          start_init = 1'b1;
          state_d    = INIT_WR;
        end else if (init_done_q && scrub_en_i) begin
          load_wait = 1'b1;
          state_d   = SCRUB_WAIT;
        end
      end
      INIT_WR: begin
        b_req_o   = 1'b1;
        b_write_o = 1'b1;
        b_addr_o  = init_addr_q;
        if (init_last) state_d = IDLE;
      end
      SCRUB_WAIT: begin
        if (init_pend_q) begin
          start_init = 1'b1;
          state_d    = INIT_WR;
        end else if (!scrub_en_i) begin
          state_d = IDLE;
        end else if (wait_cnt_q == '0) begin
          state_d = SCRUB_RD;
        end
      end
      SCRUB_RD: begin
        b_req_o = 1'b1;
        state_d = SCRUB_RSP;
      end
      SCRUB_RSP: begin
        if (rsp_corr) state_d = SCRUB_WB;
      end
      SCRUB_WB: begin
        b_req_o   = 1'b1;
        b_write_o = 1'b1;
        b_wdata_o = wb_data_q;
      end
      default: state_d = IDLE;
    endcase

    // A pending init is picked up from IDLE on the following cycle.
    if (item_done) begin
      if (init_pend_q || !scrub_en_i) begin
        state_d = IDLE;
      end else begin
        load_wait = 1'b1;
        state_d   = SCRUB_WAIT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      init_pend_q   <= 1'b0;
      init_done_q   <= 1'b0;
      init_addr_q   <= '0;
      scrub_addr_q  <= '0;
      wait_cnt_q    <= '0;
      wb_data_q     <= '0;
      uncorr_addr_q <= '0;
      uncorr_q      <= 1'b0;
      scrub_pass_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      // A request arriving on the service cycle stays pending for a rerun.
      init_pend_q  <= init_req_i | (init_pend_q & ~start_init);
      uncorr_q     <= rsp_uncorr;
      scrub_pass_q <= item_done && (scrub_addr_q == AddrMax);

      if (start_init) begin
        init_done_q <= 1'b0;
        init_addr_q <= '0;
      end else if (state_q == INIT_WR) begin
        if (init_last) init_done_q <= 1'b1;
        else           init_addr_q <= init_addr_q + SramAw'(1);
      end

      if (state_q == INIT_WR && init_last) begin
        scrub_addr_q <= '0;
      end else if (item_done) begin
        scrub_addr_q <= (scrub_addr_q == AddrMax) ? '0 : scrub_addr_q + SramAw'(1);
      end

      if (load_wait) begin
        wait_cnt_q <= scrub_period_i;
      end else if (state_q == SCRUB_WAIT && wait_cnt_q != '0) begin
        wait_cnt_q <= wait_cnt_q - PeriodW'(1);
      end

      if (rsp_corr)   wb_data_q     <= b_rdata_i;
      if (rsp_uncorr) uncorr_addr_q <= scrub_addr_q;
    end
  end

  prim_ram_sat_cnt #(.CntW(CntW)) u_corr_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (rsp_corr),
    .clr    (clr_cnt_i),
    .cnt    (corr_cnt_o)
  );

  prim_ram_sat_cnt #(.CntW(CntW)) u_uncorr_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (rsp_uncorr),
    .clr    (clr_cnt_i),
    .cnt    (uncorr_cnt_o)
  );

  assign busy_o        = !(state_q == IDLE || state_q == SCRUB_WAIT);
  assign init_done_o   = init_done_q;
  assign scrub_pass_o  = scrub_pass_q;
  assign uncorr_o      = uncorr_q;
  assign uncorr_addr_o = uncorr_addr_q;

endmodule

// File: tb/tb_prim_ram_2p_scrub_ctrl.sv
// Directed + randomized bench for prim_ram_2p_scrub_ctrl (Depth=16, CntW=2).
// A behavioural RAM (stored words plus injected, write-healed errors) answers
// reads; every port-B access and response is logged and compared against
// sequences derived from the controller's rules.
module tb_prim_ram_2p_scrub_ctrl;
  localparam int Depth = 16, Width = 32, CntW = 2, PeriodW = 4, Aw = 4;
  localparam int CntMax = (1 << CntW) - 1;
  localparam int K_RD = 0, K_WR = 1, K_RSP = 2;

  typedef struct { int kind; int addr; bit [Width-1:0] d; int cyc; } ent_t;

  logic clk = 1'b0;
  logic rst_ni, init_req_i, scrub_en_i, clr_cnt_i;
  logic [PeriodW-1:0] scrub_period_i;
  logic b_req_o, b_write_o, b_rvalid_i;
  logic [Aw-1:0] b_addr_o, uncorr_addr_o;
  logic [Width-1:0] b_wdata_o, b_rdata_i;
  logic [1:0] b_rerror_i;
  logic busy_o, init_done_o, scrub_pass_o, uncorr_o;
  logic [CntW-1:0] corr_cnt_o, uncorr_cnt_o;

  always #5 clk = ~clk;

  prim_ram_2p_scrub_ctrl #(.Depth(Depth), .Width(Width), .CntW(CntW), .PeriodW(PeriodW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .init_req_i(init_req_i), .scrub_en_i(scrub_en_i),
    .scrub_period_i(scrub_period_i), .clr_cnt_i(clr_cnt_i), .b_req_o(b_req_o),
    .b_write_o(b_write_o), .b_addr_o(b_addr_o), .b_wdata_o(b_wdata_o),
    .b_rvalid_i(b_rvalid_i), .b_rdata_i(b_rdata_i), .b_rerror_i(b_rerror_i),
    .busy_o(busy_o), .init_done_o(init_done_o), .scrub_pass_o(scrub_pass_o),
    .uncorr_o(uncorr_o), .uncorr_addr_o(uncorr_addr_o), .corr_cnt_o(corr_cnt_o),
    .uncorr_cnt_o(uncorr_cnt_o)
  );

  // RAM model: an injected error stays active until the word is rewritten.
  bit [1:0]       err_tbl [Depth];
  bit [Width-1:0] dat_tbl [Depth];
  bit [Width-1:0] ram_q   [Depth];
  int             err_gen [Depth];
  int             fix_gen [Depth];
  int lat;   // response latency in cycles, 0 = random 1..4

  function automatic bit [1:0] eff_err(int a);
    return (fix_gen[a] == err_gen[a]) ? 2'b00 : err_tbl[a];
  endfunction
  function automatic bit [Width-1:0] eff_dat(int a);
    return (eff_err(a) != 2'b00) ? dat_tbl[a] : ram_q[a];
  endfunction

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  ent_t log_q[$];
  int pass_cnt, unc_cnt, unc_run, unc_max;
  bit rsp_pend;
  int rsp_wait, rsp_addr;

  always @(negedge clk) begin
    b_rvalid_i = 1'b0;
    b_rerror_i = 2'b00;
    b_rdata_i  = '0;
    if (!rst_ni) begin
      rsp_pend = 1'b0;
      unc_run  = 0;
    end else begin
      if (b_req_o)
        log_q.push_back('{b_write_o ? K_WR : K_RD, int'(b_addr_o),
                          b_write_o ? b_wdata_o : 32'h0, cyc});
      if (scrub_pass_o) pass_cnt++;
      if (uncorr_o) begin
        unc_cnt++; unc_run++;
        if (unc_run > unc_max) unc_max = unc_run;
      end else unc_run = 0;
      if (b_req_o && b_write_o) begin
        ram_q[b_addr_o]   = b_wdata_o;
        fix_gen[b_addr_o] = err_gen[b_addr_o];
      end
      if (rsp_pend) begin
        if (rsp_wait <= 1) begin
          b_rvalid_i = 1'b1;
          b_rerror_i = eff_err(rsp_addr);
          b_rdata_i  = eff_dat(rsp_addr);
          rsp_pend   = 1'b0;
          log_q.push_back('{K_RSP, rsp_addr, 32'h0, cyc});
        end else rsp_wait--;
      end
      if (b_req_o && !b_write_o) begin
        rsp_pend = 1'b1;
        rsp_addr = int'(b_addr_o);
        rsp_wait = (lat == 0) ? int'($urandom_range(4, 1)) : lat;
      end
    end
  end

  int nchk, nerr, nxt;

  task automatic chk(input string tag, input longint obs, input longint exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic inject(input int a, input bit [1:0] e, input bit [Width-1:0] d);
    err_tbl[a] = e; dat_tbl[a] = d; err_gen[a]++;
  endtask

  function automatic int count_kind(int lb, int k);
    int c = 0;
    for (int i = lb; i < log_q.size(); i++) if (log_q[i].kind == k) c++;
    return c;
  endfunction

  // One full pass of 16 items starting at the expected scrub address.
  task automatic scrub_pass_chk(input string tag, input int per, input int l);
    ent_t exp_q[$];
    int lb, bp, bu, n, ncorr, nunc, uaddr, a;
    bit [1:0] e;
    bit ok;
    clr_cnt_i = 1'b1; step(); clr_cnt_i = 1'b0;
    chk({tag, "_clr"}, {corr_cnt_o, uncorr_cnt_o}, 0);
    ncorr = 0; nunc = 0; uaddr = 0;
    for (int i = 0; i < Depth; i++) begin
      a = (nxt + i) % Depth;
      e = eff_err(a);
      exp_q.push_back('{K_RD, a, 32'h0, 0});
      exp_q.push_back('{K_RSP, a, 32'h0, 0});
      if (e == 2'b01) begin
        exp_q.push_back('{K_WR, a, dat_tbl[a], 0});
        ncorr++;
      end else if (e[1]) begin
        nunc++; uaddr = a;
      end
    end
    scrub_period_i = PeriodW'(per); lat = l;
    lb = log_q.size(); bp = pass_cnt; bu = unc_cnt;
    scrub_en_i = 1'b1; n = 0;
    while (count_kind(lb, K_RD) < Depth && n < 600) begin step(); n++; end
    scrub_en_i = 1'b0;
    repeat (12) step();
    chk({tag, "_tmo"}, count_kind(lb, K_RD), Depth);
    ok = (log_q.size() - lb == exp_q.size());
    if (ok) for (int i = 0; i < exp_q.size(); i++) begin
      if (log_q[lb+i].kind != exp_q[i].kind || log_q[lb+i].addr != exp_q[i].addr ||
          log_q[lb+i].d != exp_q[i].d) ok = 1'b0;
      if (exp_q[i].kind == K_WR && log_q[lb+i].cyc != log_q[lb+i-1].cyc + 1) ok = 1'b0;
    end
    chk({tag, "_seq"}, ok, 1);
    chk({tag, "_corr"}, corr_cnt_o, (ncorr > CntMax) ? CntMax : ncorr);
    chk({tag, "_unc"}, uncorr_cnt_o, (nunc > CntMax) ? CntMax : nunc);
    if (nunc > 0) chk({tag, "_uaddr"}, uncorr_addr_o, uaddr);
    chk({tag, "_upulse"}, unc_cnt - bu, nunc);
    chk({tag, "_pass"}, pass_cnt - bp, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lb, n, j, prev, a, k;
    bit ok;
    nchk = 0; nerr = 0; lat = 1;
    rst_ni = 1'b0; init_req_i = 1'b0; scrub_en_i = 1'b0; clr_cnt_i = 1'b0;
    scrub_period_i = '0;
    repeat (3) step();
    rst_ni = 1'b1;
    step();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", init_done_o, 0);
    chk("rst_port", {b_req_o, b_write_o, b_addr_o}, 0);
    chk("rst_cnt", {corr_cnt_o, uncorr_cnt_o, uncorr_addr_o}, 0);

    // Zero-fill: 16 back-to-back writes, busy throughout.
    lb = log_q.size();
    init_req_i = 1'b1; step(); init_req_i = 1'b0;
    n = 0; ok = 1'b1;
    while (log_q.size() < lb + Depth && n < 60) begin
      step(); n++;
      if (log_q.size() > lb && !busy_o) ok = 1'b0;
    end
    chk("init_tmo", log_q.size() - lb, Depth);
    chk("init_busy", ok, 1);
    chk("init_done_last", init_done_o, 0);
    ok = 1'b1;
    for (int i = 0; i < Depth; i++)
      if (log_q[lb+i].kind != K_WR || log_q[lb+i].addr != i || log_q[lb+i].d != 0 ||
          log_q[lb+i].cyc != log_q[lb].cyc + i) ok = 1'b0;
    chk("init_seq", ok, 1);
    step();
    chk("init_done", init_done_o, 1);
    chk("init_idle", busy_o, 0);

    // Clean scrub, period 0, latency 1: addresses 0..15 then 0, 3-cycle pitch.
    lb = log_q.size(); prev = pass_cnt;
    scrub_period_i = '0; lat = 1; scrub_en_i = 1'b1; n = 0;
    while (count_kind(lb, K_RD) < Depth + 1 && n < 200) begin step(); n++; end
    scrub_en_i = 1'b0;
    chk("clean_tmo", count_kind(lb, K_RD), Depth + 1);
    chk("clean_pass", pass_cnt - prev, 1);
    ok = 1'b1; j = 0; prev = -1;
    for (int i = lb; i < log_q.size(); i++) begin
      if (log_q[i].kind == K_WR) ok = 1'b0;
      if (log_q[i].kind == K_RD) begin
        if (log_q[i].addr != j % Depth) ok = 1'b0;
        if (prev >= 0 && log_q[i].cyc - prev != 3) ok = 1'b0;
        prev = log_q[i].cyc; j++;
      end
    end
    chk("clean_seq", ok, 1);
    repeat (12) step();
    chk("clean_stop", {b_req_o, busy_o}, 0);
    nxt = 1;

    // Random pass: fixed errors at 5 (correctable) and 9 (uncorrectable)
    // plus a few random correctable words, random period and latency.
    inject(5, 2'b01, 32'hDEADBEEF);
    inject(9, 2'b10, $urandom);
    k = $urandom_range(2, 0);
    for (int i = 0; i < k; i++) begin
      a = $urandom_range(15, 0);
      if (a != 5 && a != 9 && eff_err(a) == 2'b00) inject(a, 2'b01, $urandom);
    end
    scrub_pass_chk("rand", $urandom_range(3, 0), 0);
    chk("upulse_width", unc_max, 1);

    // Saturation: five correctable words in one pass.
    for (int i = 0; i < 5; i++) inject(i, 2'b01, $urandom);
    scrub_pass_chk("sat", 0, 1);

    // Counter clear coincident with a further correctable error.
    inject(nxt, 2'b01, 32'h12345678);
    clr_cnt_i = 1'b0; lat = 1; scrub_period_i = '0;
    scrub_en_i = 1'b1; n = 0;
    while (!(b_rvalid_i && b_rerror_i == 2'b01) && n < 40) begin step(); n++; end
    chk("clr_tmo", b_rvalid_i && b_rerror_i == 2'b01, 1);
    chk("clr_before", corr_cnt_o, CntMax);
    clr_cnt_i = 1'b1; step(); clr_cnt_i = 1'b0; scrub_en_i = 1'b0;
    chk("clr_wins", corr_cnt_o, 0);
    repeat (12) step();

    // Init request while a read waits for its latency-4 response.
    for (int i = 0; i < Depth; i++) inject(i, 2'b00, 32'h0);
    lat = 4; lb = log_q.size(); scrub_en_i = 1'b1; n = 0;
    while (count_kind(lb, K_RD) < 1 && n < 40) begin step(); n++; end
    step();
    init_req_i = 1'b1; step(); init_req_i = 1'b0;
    n = 0;
    while (log_q.size() < lb + Depth + 3 && n < 300) begin step(); n++; end
    chk("irsp_tmo", log_q.size() >= lb + Depth + 3, 1);
    ok = (log_q.size() >= lb + Depth + 3);
    if (ok) begin
      if (log_q[lb].kind != K_RD || log_q[lb+1].kind != K_RSP ||
          log_q[lb+1].cyc != log_q[lb].cyc + 4) ok = 1'b0;
      for (int i = 0; i < Depth; i++)
        if (log_q[lb+2+i].kind != K_WR || log_q[lb+2+i].addr != i || log_q[lb+2+i].d != 0)
          ok = 1'b0;
      if (log_q[lb+2+Depth].kind != K_RD || log_q[lb+2+Depth].addr != 0) ok = 1'b0;
    end
    chk("irsp_seq", ok, 1);
    chk("irsp_done", init_done_o, 1);
    scrub_en_i = 1'b0;
    repeat (12) step();

    // Reset in the middle of a zero-fill.
    lb = log_q.size();
    init_req_i = 1'b1; step(); init_req_i = 1'b0;
    n = 0;
    while (count_kind(lb, K_WR) < 5 && n < 40) begin step(); n++; end
    chk("rinit_busy", busy_o, 1);
    rst_ni = 1'b0; #1;
    chk("rinit_outs", {b_req_o, b_write_o, b_addr_o, b_wdata_o, busy_o, init_done_o,
                       scrub_pass_o, uncorr_o, uncorr_addr_o, corr_cnt_o, uncorr_cnt_o}, 0);
    repeat (2) step();
    rst_ni = 1'b1; scrub_en_i = 1'b1;
    repeat (6) step();
    chk("rinit_nostart", {b_req_o, init_done_o, busy_o}, 0);
    scrub_en_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
